// File: rtl/mips_divider.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Quotient is returned on Lo and remainder on Hi, with a one-cycle validOut pulse.
// The divider works on operand magnitudes, and a final cycle applies the sign fixup.
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] dvd;    // dividend bits shift out the top; quotient bits shift in at the bottom
  logic [WIDTH-1:0] dsr;    // divisor magnitude
  logic [WIDTH-1:0] a_cap;  // raw dividend, returned on Hi for divide-by-zero
  logic             sgn, a_neg, b_neg, dz;

  // One restoring step: bring in the next dividend bit, then try to subtract.
  // The shifted remainder is always below 2*divisor, so WIDTH+1 bits hold it.
  // In that case the top bit of the difference is exactly the borrow.
  logic [WIDTH:0]   rem_sh, trial;
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr};

  // Sign fixup: quotient truncates toward zero; remainder follows the dividend.
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = (sgn && (a_neg ^ b_neg)) ? (~dvd + 1'b1) : dvd;
  assign r_fix = (sgn && a_neg) ? (~rem + 1'b1) : rem;

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      a_cap    <= '0;
      sgn      <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      dz       <= 1'b0;
      validOut <= 1'b0;
      busy     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      validOut <= 1'b0;
      case (state)
        IDLE: begin
          if (validIn) begin
            sgn   <= sign;
            a_neg <= SrcA[WIDTH-1];
            b_neg <= SrcB[WIDTH-1];
            dz    <= (SrcB == '0);
            a_cap <= SrcA;
            dvd   <= (sign && SrcA[WIDTH-1]) ? (~SrcA + 1'b1) : SrcA;
            dsr   <= (sign && SrcB[WIDTH-1]) ? (~SrcB + 1'b1) : SrcB;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          if (!validIn) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (!validIn) begin
            state <= IDLE;
          end else begin
            Lo       <= dz ? '1 : q_fix;
            Hi       <= dz ? a_cap : r_fix;
            validOut <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          // DONE: validIn is ignored; always return to IDLE
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_divider.sv
// Self-checking bench for mips_divider.
// The driver pushes expected results into a scoreboard queue, and an independent monitor pops and compares on validOut.
module tb_mips_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn;
  logic        sign;
  logic [31:0] SrcA, SrcB;
  logic        validOut;
  logic [31:0] Hi, Lo;
  logic        busy;

  mips_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .sign(sign),
    .SrcA(SrcA), .SrcB(SrcB), .validOut(validOut),
    .Hi(Hi), .Lo(Lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  logic [31:0] last_hi = 32'h0, last_lo = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic with SystemVerilog's truncating / and %.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'h0, a});
      sbv = longint'({32'h0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every validOut pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && validOut) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_validOut: got Hi=%h Lo=%h expected no pulse (cycle %0d)", Hi, Lo, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Lo", Lo, e.lo);
        chk("Hi", Hi, e.hi);
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push_exp(input logic s, input logic [31:0] a, input logic [31:0] b, input int at);
    logic [63:0] m;
    exp_t e;
    m = model(s, a, b);
    e.hi = m[63:32];
    e.lo = m[31:0];
    e.cyc = at;
    sb.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  // Wait (bounded) for validOut; returns its cycle and the busy cycles seen.
  task automatic wait_done(output int vcyc, output int nbusy);
    vcyc = -1;
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (validOut) begin
        vcyc = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout: got no validOut expected one within 60 cycles (cycle %0d)", cyc);
  endtask

  // Full operation; optionally scramble operands after the start edge.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int vcyc, output int nbusy);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    sign = s; SrcA = a; SrcB = b; validIn = 1'b1;
    push_exp(s, a, b, c0 + 34);
    if (scramble) begin
      @(posedge clk); #1;
      SrcA = $urandom; SrcB = $urandom; sign = ~s;
    end
    wait_done(vcyc, nbusy);
    validIn = 1'b0;
  endtask

  initial begin
    int vc, nb, v0;
    logic [31:0] a, b;
    logic s;

    reset = 1'b1; validIn = 1'b0; sign = 1'b0; SrcA = '0; SrcB = '0;
    #1;
    chk("reset_validOut", {31'b0, validOut}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_Hi", Hi, 32'h0);
    chk("reset_Lo", Lo, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic DIVU: 34-cycle latency, 33 busy cycles
    run_op(1'b0, 32'd100, 32'd7, 1'b0, vc, nb);
    chk("busy_cycles", 32'(nb), 32'd33);

    // Signed cases, divide-by-zero, overflow and all-ones DIVU
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, vc, nb);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, vc, nb);
    run_op(1'b0, 32'd5, 32'd0, 1'b0, vc, nb);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, vc, nb);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, vc, nb);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, vc, nb);

    // Operand changes after the start edge must not matter
    run_op(1'b0, 32'd100, 32'd7, 1'b1, vc, nb);

    // Back-to-back: validIn stays high through DONE with new operands
    @(posedge clk); #1;
    v0 = cyc;
    sign = 1'b0; SrcA = 32'd100; SrcB = 32'd7; validIn = 1'b1;
    push_exp(1'b0, 32'd100, 32'd7, v0 + 34);
    wait_done(vc, nb);
    SrcA = 32'd81; SrcB = 32'd9;
    push_exp(1'b0, 32'd81, 32'd9, vc + 35);
    wait_done(vc, nb);
    validIn = 1'b0;

    // Abort in DIV: no pulse, Hi/Lo hold the previous result
    @(posedge clk); #1;
    v0 = n_valid;
    sign = 1'b0; SrcA = 32'd1000; SrcB = 32'd3; validIn = 1'b1;
    repeat (10) @(posedge clk);
    #1 validIn = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_no_pulse", 32'(n_valid), 32'(v0));
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_Hi_hold", Hi, last_hi);
    chk("abort_Lo_hold", Lo, last_lo);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: b = $urandom;
      endcase
      if (i % 10 == 3) a = 32'h8000_0000;
      run_op(s, a, b, 1'b0, vc, nb);
    end

    // Reset mid-operation: immediate clear, and no pulse afterwards
    @(posedge clk); #1;
    sign = 1'b1; SrcA = 32'hFFFF_FF00; SrcB = 32'd5; validIn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_validOut", {31'b0, validOut}, 32'h0);
    chk("midreset_busy", {31'b0, busy}, 32'h0);
    chk("midreset_Hi", Hi, 32'h0);
    chk("midreset_Lo", Lo, 32'h0);
    validIn = 1'b0;
    v0 = n_valid;
    @(posedge clk); #1 reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("midreset_no_pulse", 32'(n_valid), 32'(v0));
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
